// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared arithmetic types and saturation limits
// Provides the multiplier FSM state type and signed saturation limits for a
// given result width (valid for widths up to 64 bits).
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        FINISH = 2'd2
    } mul_state_t;

    // Largest positive two's-complement value of the given width: 2^(w-1)-1.
    function automatic logic [63:0] sat_max(input int width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    // Most negative two's-complement value of the given width: -2^(w-1),
    // sign-extended to 64 bits.
    function automatic logic [63:0] sat_min(input int width);
        return ~sat_max(width);
    endfunction

endpackage

// File: rtl/fxp_sat.sv
// rtl/fxp_sat.sv - fixed-point rescale, sign restore and saturation
// Ports:
//   mag    in  MAG_W  unsigned full-precision magnitude (2*QBITS fraction bits)
//   neg    in  1      result is negative
//   result out WIDTH  signed Q-format value, truncated toward zero
//   ovf    out 1      result was clamped to a saturation limit
module fxp_sat
    import arith_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int QBITS = 8,
    parameter int MAG_W = 2 * WIDTH
) (
    input  logic [MAG_W-1:0] mag,
    input  logic             neg,
    output logic [WIDTH-1:0] result,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(sat_max(WIDTH));
    localparam logic [WIDTH-1:0] MIN_VAL = WIDTH'(sat_min(WIDTH));
    // Magnitude limits: the negative side reaches one step further.
    localparam logic [MAG_W-1:0] POS_LIM = MAG_W'(sat_max(WIDTH));
    localparam logic [MAG_W-1:0] NEG_LIM = POS_LIM + MAG_W'(1);

    logic [MAG_W-1:0] m;

    always_comb begin
        result = '0;
        ovf    = 1'b0;
        // Shifting the magnitude (not the signed value) truncates toward zero.
        m      = mag >> QBITS;
        if (!neg) begin
            if (m > POS_LIM) begin
                result = MAX_VAL;
                ovf    = 1'b1;
            end else begin
                result = m[WIDTH-1:0];
            end
        end else begin
            if (m > NEG_LIM) begin
                result = MIN_VAL;
                ovf    = 1'b1;
            end else begin
                // Zero magnitude negates to zero, so -0 cannot appear.
                result = WIDTH'(0) - m[WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/mul.sv
// rtl/mul.sv - sequential signed fixed-point shift-add multiplier
// Ports:
//   i_clk    in  1      clock, rising edge
//   i_rst_n  in  1      synchronous active-low reset
//   i_a      in  WIDTH  signed multiplicand, sampled with i_start
//   i_b      in  WIDTH  signed multiplier, sampled with i_start
//   i_start  in  1      start / restart an operation
//   o_result out WIDTH  signed Q-format product, held until next start
//   o_ovf    out 1      product was saturated (qualified by o_valid)
//   done     out 1      no operation in flight
//   o_valid  out 1      o_result/o_ovf hold a completed product
module mul
    import arith_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int QBITS = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_start,
    output logic [WIDTH-1:0] o_result,
    output logic             o_ovf,
    output logic             done,
    output logic             o_valid
);

    localparam int ACC_W = 2 * WIDTH;
    localparam int CW    = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    mul_state_t       state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [ACC_W-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [ACC_W-1:0] acc;
    logic             neg;

    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH-1:0] sat_result;
    logic             sat_ovf;

    // The most negative input maps to 2^(WIDTH-1), which still fits unsigned.
    assign abs_a = i_a[WIDTH-1] ? (WIDTH'(0) - i_a) : i_a;
    assign abs_b = i_b[WIDTH-1] ? (WIDTH'(0) - i_b) : i_b;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        done      = (state == IDLE);
        case (state)
            IDLE:    state_nxt = IDLE;
            BUSY:    if (cnt == LAST_ITER) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // A start aborts whatever is in flight.
        if (i_start) begin
            state_nxt = BUSY;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            neg      <= 1'b0;
            o_result <= '0;
            o_ovf    <= 1'b0;
            o_valid  <= 1'b0;
        end else if (i_start) begin
            cnt      <= '0;
            mcand    <= ACC_W'(abs_a);
            mplier   <= abs_b;
            acc      <= '0;
            neg      <= i_a[WIDTH-1] ^ i_b[WIDTH-1];
            o_result <= '0;
            o_ovf    <= 1'b0;
            o_valid  <= 1'b0;
        end else begin
            case (state)
                BUSY: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                end
                FINISH: begin
                    o_result <= sat_result;
                    o_ovf    <= sat_ovf;
                    o_valid  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    fxp_sat #(
        .WIDTH (WIDTH),
        .QBITS (QBITS),
        .MAG_W (ACC_W)
    ) u_fxp_sat (
        .mag    (acc),
        .neg    (neg),
        .result (sat_result),
        .ovf    (sat_ovf)
    );

endmodule
